// File: rtl/imem_load_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_load_arbiter_pkg
// Shared definitions for the instruction-memory load arbiter:
//   - default address/data widths and loader idle timeout
//   - arbiter state encoding (RUN / LOAD / SETTLE)
// No ports (package).
// -----------------------------------------------------------------------------
package imem_load_arbiter_pkg;

  localparam int DEF_AW          = 7;
  localparam int DEF_DW          = 8;
  localparam int DEF_IDLE_CYCLES = 16;

  // RUN    : CPU owns the memory, loader writes may still slip in
  // LOAD   : program is being written, CPU is held
  // SETTLE : single cycle that releases the CPU with a restart pulse
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/imem_load_arbiter_pulse_sync.sv
// -----------------------------------------------------------------------------
// pulse_sync
// Brings the asynchronous loader write-enable pin into the clk domain and turns
// each rising edge into a single-cycle strobe.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   async_in   in   asynchronous level input (loader write-enable pin)
//   pulse      out  registered one-cycle strobe, 3 clk after the pin rises
//   pulse_next out  high one cycle before pulse (lets the owner pre-decode)
// -----------------------------------------------------------------------------
module pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse,
  output logic pulse_next
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic pulse_q, pulse_d;

  // sync1/sync2 resolve metastability; sync3 is the delayed copy for edge detect.
  // The strobe itself is registered so downstream logic sees a clean flop output.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    pulse_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse      = pulse_q;
  assign pulse_next = pulse_d;

endmodule

// File: rtl/imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// imem_load_arbiter
// Shares the single-port instruction memory between the pin-level program
// loader and the CPU fetch port. While a program is being written the CPU is
// held; once the loader has been quiet for IDLE_CYCLES cycles the CPU is
// released with a one-cycle restart pulse.
//
// Optional build macro: IMEM_LOAD_CHECKSUM_EN adds output ld_csum, the XOR of
// every byte written since the last RUN->LOAD transition.
//
// Parameters: AW (address width), DW (data width), IDLE_CYCLES (>=2).
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   ld_we_async              loader write-enable pin (asynchronous)
//   ld_addr, ld_data         loader address / data pins
//   cpu_req, cpu_addr        CPU fetch request / address
//   cpu_gnt                  fetch accepted this cycle (combinational)
//   cpu_rdata, cpu_rvalid    fetch data and its registered valid
//   cpu_hold                 CPU must stall (registered)
//   cpu_restart              one-cycle pulse, CPU resets PC to 0 (registered)
//   mem_en, mem_we           memory enable / write enable (combinational)
//   mem_addr, mem_wdata      memory address / write data
//   mem_rdata                memory read data, 1-cycle latency
//   ld_busy                  arbiter is not in RUN
//   ld_count                 bytes written since last RUN->LOAD (saturating)
//   ld_csum                  (IMEM_LOAD_CHECKSUM_EN only) XOR of written bytes
// -----------------------------------------------------------------------------
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we_async,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_hold,
  output logic          cpu_restart,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          ld_busy,
  output logic [AW:0]   ld_count
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [DW-1:0] ld_csum
`endif
);

  localparam int IW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(1) << AW;

  logic ld_stb;
  logic ld_stb_next;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_inc;
  logic          cpu_hold_q, cpu_hold_d;
  logic          cpu_restart_q, cpu_restart_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  pulse_sync u_pulse_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (ld_we_async),
    .pulse      (ld_stb),
    .pulse_next (ld_stb_next)
  );

  // Memory port mux: a loader strobe always wins, the CPU is only granted in RUN.
  always_comb begin
    cpu_gnt   = cpu_req && (state_q == ST_RUN) && !ld_stb;
    mem_en    = ld_stb || cpu_gnt;
    mem_we    = ld_stb;
    mem_addr  = ld_stb ? ld_addr : cpu_addr;
    mem_wdata = ld_data;
  end

  // Next-state decode. cpu_hold/cpu_restart are derived from the next state so
  // they appear in the first cycle of the state they belong to. The restart is
  // suppressed when a loader strobe is already on its way into SETTLE, since
  // that strobe sends the FSM straight back to LOAD.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    count_d   = count_q;
    count_inc = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (ld_stb) begin
          state_d = ST_LOAD;
          count_d = CW'(1);
          idle_d  = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d  = ld_data;
`endif
        end
      end
      ST_LOAD: begin
        if (ld_stb) begin
          count_d = count_inc;
          idle_d  = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d  = csum_q ^ ld_data;
`endif
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_SETTLE;
          idle_d  = '0;
        end else begin
          idle_d  = idle_q + IW'(1);
        end
      end
      ST_SETTLE: begin
        idle_d = '0;
        if (ld_stb) begin
          state_d = ST_LOAD;
          count_d = count_inc;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d  = csum_q ^ ld_data;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        idle_d  = '0;
      end
    endcase

    cpu_hold_d    = (state_d != ST_RUN);
    cpu_restart_d = (state_d == ST_SETTLE) && !ld_stb_next;
    cpu_rvalid_d  = cpu_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      idle_q        <= '0;
      count_q       <= '0;
      cpu_hold_q    <= 1'b0;
      cpu_restart_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      count_q       <= count_d;
      cpu_hold_q    <= cpu_hold_d;
      cpu_restart_q <= cpu_restart_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Read data comes straight from the memory, which already has one cycle of
  // latency; it lines up with the registered cpu_rvalid.
  assign cpu_rdata   = mem_rdata;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_hold    = cpu_hold_q;
  assign cpu_restart = cpu_restart_q;
  assign ld_busy     = (state_q != ST_RUN);
  assign ld_count    = count_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign ld_csum     = csum_q;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_load_arbiter
// Directed bench for imem_load_arbiter with a behavioural instruction memory,
// a shadow copy of the expected memory contents and a queue of expected fetch
// data that is drained whenever the DUT reports cpu_rvalid.
// -----------------------------------------------------------------------------
module tb_imem_load_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          ld_we_async;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_hold;
  logic          cpu_restart;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          ld_busy;
  logic [AW:0]   ld_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DW-1:0] ld_csum;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] tbMem     [0:(1<<AW)-1];
  logic [DW-1:0] shadowMem [0:(1<<AW)-1];
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] expData;

  imem_load_arbiter #(.AW(AW), .DW(DW), .IDLE_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_we_async (ld_we_async),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_gnt     (cpu_gnt),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .ld_busy     (ld_busy),
    .ld_count    (ld_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .ld_csum     (ld_csum)
`endif
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbMem[mem_addr] <= mem_wdata;
      else        mem_rdata       <= tbMem[mem_addr];
    end
  end

  // Every returned fetch must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && cpu_rvalid === 1'b1) begin
      vectors++;
      assert (expQ.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpected_rvalid observed=1 expected=0");
      end
      if (expQ.size() != 0) begin
        expData = expQ.pop_front();
        vectors++;
        assert (cpu_rdata === expData) else begin
          miscompares++;
          $error("[TB] FAIL fetch_rdata observed=%0h expected=%0h", cpu_rdata, expData);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and present a CPU request for it
  task automatic applyStimulus(input logic req, input logic [AW-1:0] addr);
    tick();
    cpu_req  = req;
    cpu_addr = addr;
  endtask

  // One fetch cycle; a granted fetch queues the shadow data for the monitor
  task automatic doFetch(input logic [AW-1:0] addr, input logic expectGnt, input string tag);
    applyStimulus(1'b1, addr);
    @(negedge clk);
    checkOutput({tag, "_gnt"}, 32'(cpu_gnt), 32'(expectGnt));
    if (expectGnt) begin
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
      checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      expQ.push_back(shadowMem[addr]);
    end
    applyStimulus(1'b0, '0);
    @(negedge clk);
    checkOutput({tag, "_rvalid"}, 32'(cpu_rvalid), 32'(expectGnt));
  endtask

  // Pin-level write: raise the pin, expect the strobe three clocks later,
  // optionally collide it with a CPU request, then check the LOAD state.
  task automatic loadByte(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic reqAtStb, input int expCount, input string tag);
    tick();
    ld_addr     = addr;
    ld_data     = data;
    ld_we_async = 1'b1;
    tick();
    tick();
    tick();
    cpu_req  = reqAtStb;
    cpu_addr = 7'h05;
    @(negedge clk);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(data));
    checkOutput({tag, "_gnt"}, 32'(cpu_gnt), 32'd0);
    shadowMem[addr] = data;
    tick();
    cpu_req     = 1'b0;
    ld_we_async = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(ld_busy), 32'd1);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, "_count"}, 32'(ld_count), 32'(expCount));
    checkOutput({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      tbMem[i]     = 8'hA0 ^ 8'(i);
      shadowMem[i] = 8'hA0 ^ 8'(i);
    end
    rst         = 1'b1;
    ld_we_async = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    cpu_req     = 1'b0;
    cpu_addr    = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_restart", 32'(cpu_restart), 32'd0);
    checkOutput("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst_busy", 32'(ld_busy), 32'd0);
    checkOutput("rst_count", 32'(ld_count), 32'd0);
    tick();
    rst = 1'b0;

    // Plain fetch in RUN: address 0x05 holds 0xA5
    doFetch(7'h05, 1'b1, "t1_fetch");

    // First loader write moves RUN -> LOAD
    loadByte(7'h10, 8'h3C, 1'b0, 1, "t2_wr0");

    // Three more writes with a held-off fetch in between, then idle timeout
    loadByte(7'h11, 8'h5A, 1'b0, 2, "t3_wr1");
    doFetch(7'h05, 1'b0, "t3_held");
    loadByte(7'h12, 8'h77, 1'b0, 3, "t3_wr2");
    loadByte(7'h13, 8'h99, 1'b0, 4, "t3_wr3");
    repeat (15) tick();
    @(negedge clk);
    checkOutput("t3_idle15_restart", 32'(cpu_restart), 32'd0);
    checkOutput("t3_idle15_busy", 32'(ld_busy), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("t3_settle_restart", 32'(cpu_restart), 32'd1);
    checkOutput("t3_settle_hold", 32'(cpu_hold), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("t3_run_restart", 32'(cpu_restart), 32'd0);
    checkOutput("t3_run_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t3_run_busy", 32'(ld_busy), 32'd0);
    checkOutput("t3_run_count", 32'(ld_count), 32'd4);

    // Loaded bytes are visible to the CPU
    doFetch(7'h10, 1'b1, "t3_fetch10");
    doFetch(7'h13, 1'b1, "t3_fetch13");

    // Fetch request on the strobe cycle loses to the write
    loadByte(7'h20, 8'hC3, 1'b1, 1, "t4_collide");

    // Time a strobe to land exactly in the SETTLE cycle
    repeat (13) tick();
    ld_addr     = 7'h21;
    ld_data     = 8'h81;
    ld_we_async = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checkOutput("t5_pre_restart", 32'(cpu_restart), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_settle_we", 32'(mem_we), 32'd1);
    checkOutput("t5_settle_addr", 32'(mem_addr), 32'h21);
    checkOutput("t5_settle_restart", 32'(cpu_restart), 32'd0);
    checkOutput("t5_settle_hold", 32'(cpu_hold), 32'd1);
    shadowMem[7'h21] = 8'h81;
    tick();
    ld_we_async = 1'b0;
    @(negedge clk);
    checkOutput("t5_reload_busy", 32'(ld_busy), 32'd1);
    checkOutput("t5_reload_restart", 32'(cpu_restart), 32'd0);
    checkOutput("t5_reload_count", 32'(ld_count), 32'd2);
    repeat (15) tick();
    @(negedge clk);
    checkOutput("t5_idle_restart", 32'(cpu_restart), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_final_restart", 32'(cpu_restart), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("t5_final_busy", 32'(ld_busy), 32'd0);
    doFetch(7'h21, 1'b1, "t5_fetch21");

    // Reset in the middle of LOAD
    loadByte(7'h30, 8'h0F, 1'b0, 1, "t6_wr0");
    loadByte(7'h31, 8'hF0, 1'b0, 2, "t6_wr1");
`ifdef IMEM_LOAD_CHECKSUM_EN
    checkOutput("t6_csum", 32'(ld_csum), 32'hFF);
`endif
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t6_rst_busy", 32'(ld_busy), 32'd0);
    checkOutput("t6_rst_count", 32'(ld_count), 32'd0);
    checkOutput("t6_rst_restart", 32'(cpu_restart), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    checkOutput("t6_rst_csum", 32'(ld_csum), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("t6_after_restart", 32'(cpu_restart), 32'd0);
    doFetch(7'h31, 1'b1, "t6_fetch31");

    tick();
    tick();
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
